ps2_kbd_matrix: RTL and testbench



---
 rtl/ps2_kbd_pkg.sv | 111 +++++++++++
 rtl/ps2_rx.sv | 109 ++++++++++
 rtl/ps2_kbd_matrix.sv | 82 ++++++++
 tb/tb_ps2_kbd_matrix.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_kbd_pkg.sv
// Shared types, PS/2 set-2 prefix codes and the scan-code to Spectrum
// key-matrix map used by the keyboard responder.
package ps2_kbd_pkg;

    localparam int DEF_FILTER_LEN     = 8;
    localparam int DEF_TIMEOUT_CYCLES = 16383;

    localparam logic [7:0] PS2_REL    = 8'hF0;
    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_PAUSE  = 8'hE1;
    localparam logic [7:0] PS2_BAT_OK = 8'hAA;
    localparam logic [7:0] PS2_OVR_LO = 8'h00;
    localparam logic [7:0] PS2_OVR_HI = 8'hFF;

    typedef enum logic {
        RX_IDLE  = 1'b0,
        RX_SHIFT = 1'b1
    } rx_state_e;

    // Encoding is {ext, rel} so the flags can be read straight off the state.
    typedef enum logic [1:0] {
        DEC_IDLE    = 2'b00,
        DEC_REL     = 2'b01,
        DEC_EXT     = 2'b10,
        DEC_EXT_REL = 2'b11
    } dec_state_e;

    typedef struct packed {
        logic       valid;
        logic [2:0] row;
        logic [2:0] col;
    } key_loc_t;

    function automatic dec_state_e dec_flags(input logic ext, input logic rel);
        dec_state_e s;
        case ({ext, rel})
            2'b01:   s = DEC_REL;
            2'b10:   s = DEC_EXT;
            2'b11:   s = DEC_EXT_REL;
            default: s = DEC_IDLE;
        endcase
        return s;
    endfunction

    function automatic key_loc_t key_at(input logic [2:0] row, input logic [2:0] col);
        key_loc_t k;
        k.valid = 1'b1;
        k.row   = row;
        k.col   = col;
        return k;
    endfunction

    // Only right-ctrl (symbol shift) and keypad enter survive an E0 prefix.
    function automatic key_loc_t key_lookup(input logic [7:0] code, input logic ext);
        key_loc_t k;
        k = '0;
        if (ext) begin
            case (code)
                8'h14:   k = key_at(3'd7, 3'd1);
                8'h5A:   k = key_at(3'd6, 3'd0);
                default: k = '0;
            endcase
        end else begin
            case (code)
                8'h12, 8'h59: k = key_at(3'd0, 3'd0);
                8'h1A: k = key_at(3'd0, 3'd1);
                8'h22: k = key_at(3'd0, 3'd2);
                8'h21: k = key_at(3'd0, 3'd3);
                8'h2A: k = key_at(3'd0, 3'd4);
                8'h1C: k = key_at(3'd1, 3'd0);
                8'h1B: k = key_at(3'd1, 3'd1);
                8'h23: k = key_at(3'd1, 3'd2);
                8'h2B: k = key_at(3'd1, 3'd3);
                8'h34: k = key_at(3'd1, 3'd4);
                8'h15: k = key_at(3'd2, 3'd0);
                8'h1D: k = key_at(3'd2, 3'd1);
                8'h24: k = key_at(3'd2, 3'd2);
                8'h2D: k = key_at(3'd2, 3'd3);
                8'h2C: k = key_at(3'd2, 3'd4);
                8'h16: k = key_at(3'd3, 3'd0);
                8'h1E: k = key_at(3'd3, 3'd1);
                8'h26: k = key_at(3'd3, 3'd2);
                8'h25: k = key_at(3'd3, 3'd3);
                8'h2E: k = key_at(3'd3, 3'd4);
                8'h45: k = key_at(3'd4, 3'd0);
                8'h46: k = key_at(3'd4, 3'd1);
                8'h3E: k = key_at(3'd4, 3'd2);
                8'h3D: k = key_at(3'd4, 3'd3);
                8'h36: k = key_at(3'd4, 3'd4);
                8'h4D: k = key_at(3'd5, 3'd0);
                8'h44: k = key_at(3'd5, 3'd1);
                8'h43: k = key_at(3'd5, 3'd2);
                8'h3C: k = key_at(3'd5, 3'd3);
                8'h35: k = key_at(3'd5, 3'd4);
                8'h5A: k = key_at(3'd6, 3'd0);
                8'h4B: k = key_at(3'd6, 3'd1);
                8'h42: k = key_at(3'd6, 3'd2);
                8'h3B: k = key_at(3'd6, 3'd3);
                8'h33: k = key_at(3'd6, 3'd4);
                8'h29: k = key_at(3'd7, 3'd0);
                8'h14: k = key_at(3'd7, 3'd1);
                8'h3A: k = key_at(3'd7, 3'd2);
                8'h31: k = key_at(3'd7, 3'd3);
                8'h32: k = key_at(3'd7, 3'd4);
                default: k = '0;
            endcase
        end
        return k;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 device-to-host byte receiver: input synchronisers, ps2clk glitch
// filter, 11-bit frame shifter with parity/stop checks and an idle timeout.
module ps2_rx
    import ps2_kbd_pkg::*;
#(
    parameter int FILTER_LEN     = DEF_FILTER_LEN,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic       clk14,
    input  logic       reset_n,
    input  logic       ps2clk,
    input  logic       ps2data,
    output logic [7:0] scancode,
    output logic       scancode_valid,
    output logic       rx_error
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

    logic                  clk_s1, clk_s2, dat_s1, dat_s2;
    logic [FILTER_LEN-1:0] clk_hist;
    logic                  clk_f;
    logic                  strobe;
    rx_state_e             rx_state;
    logic [3:0]            bitcnt;
    logic [8:0]            shreg;
    logic [TW-1:0]         tmo;

    // Lines idle high, so every conditioning flop resets to 1.
    always_ff @(posedge clk14) begin
        if (!reset_n) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
            clk_hist <= '1;
            clk_f    <= 1'b1;
            strobe   <= 1'b0;
        end else begin
            clk_s1   <= ps2clk;
            clk_s2   <= clk_s1;
            dat_s1   <= ps2data;
            dat_s2   <= dat_s1;
            clk_hist <= {clk_hist[FILTER_LEN-2:0], clk_s2};
            strobe   <= 1'b0;
            if (&clk_hist && !clk_f) begin
                clk_f <= 1'b1;
            end else if (~|clk_hist && clk_f) begin
                clk_f  <= 1'b0;
                strobe <= 1'b1;
            end
        end
    end

    // scancode_valid is a bare one-cycle valid with no ready: the consumer
    // must take scancode in the cycle the strobe is high.
    always_ff @(posedge clk14) begin
        if (!reset_n) begin
            rx_state       <= RX_IDLE;
            bitcnt         <= '0;
            shreg          <= '0;
            tmo            <= '0;
            scancode       <= '0;
            scancode_valid <= 1'b0;
            rx_error       <= 1'b0;
        end else begin
            scancode_valid <= 1'b0;
            rx_error       <= 1'b0;
            if (strobe || rx_state == RX_IDLE) begin
                tmo <= '0;
            end else begin
                tmo <= tmo + 1'b1;
            end
            case (rx_state)
                RX_IDLE: begin
                    if (strobe && !dat_s2) begin
                        rx_state <= RX_SHIFT;
                        bitcnt   <= 4'd1;
                    end
                end
                RX_SHIFT: begin
                    if (strobe) begin
                        if (bitcnt == 4'd10) begin
                            // shreg holds d0..d7 and parity; the current bit is stop.
                            rx_state <= RX_IDLE;
                            bitcnt   <= '0;
                            if ((^shreg) && dat_s2) begin
                                scancode       <= shreg[7:0];
                                scancode_valid <= 1'b1;
                            end else begin
                                rx_error <= 1'b1;
                            end
                        end else begin
                            shreg  <= {dat_s2, shreg[8:1]};
                            bitcnt <= bitcnt + 4'd1;
                        end
                    end else if (tmo == TMO_MAX) begin
                        rx_state <= RX_IDLE;
                        bitcnt   <= '0;
                        rx_error <= 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ps2_kbd_matrix.sv
// PS/2 keyboard to Spectrum 8x5 membrane emulation: decodes make/break
// sequences into a key matrix and answers the ULA half-row scan on A15..A8.
module ps2_kbd_matrix
    import ps2_kbd_pkg::*;
#(
    parameter int FILTER_LEN     = DEF_FILTER_LEN,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic       clk14,
    input  logic       reset_n,
    input  logic       ps2clk,
    input  logic       ps2data,
    input  logic [7:0] a,
    output logic [4:0] kbcolumns,
    output logic [7:0] scancode,
    output logic       scancode_valid,
    output logic       rx_error
);

    dec_state_e      dec_state;
    logic            dec_rel, dec_ext;
    logic [7:0][4:0] matrix;
    key_loc_t        key;
    logic [4:0]      pressed;

    ps2_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk14          (clk14),
        .reset_n        (reset_n),
        .ps2clk         (ps2clk),
        .ps2data        (ps2data),
        .scancode       (scancode),
        .scancode_valid (scancode_valid),
        .rx_error       (rx_error)
    );

    assign dec_rel = dec_state[0];
    assign dec_ext = dec_state[1];

    always_comb begin
        key = key_lookup(scancode, dec_ext);
    end

    always_ff @(posedge clk14) begin
        if (!reset_n) begin
            dec_state <= DEC_IDLE;
            matrix    <= '0;
        end else if (scancode_valid) begin
            if (scancode == PS2_REL) begin
                dec_state <= dec_flags(dec_ext, 1'b1);
            end else if (scancode == PS2_EXT) begin
                dec_state <= dec_flags(1'b1, dec_rel);
            end else if (scancode == PS2_PAUSE ||
                         (scancode == PS2_BAT_OK && dec_state == DEC_IDLE)) begin
                dec_state <= dec_state;
            end else if (scancode == PS2_OVR_LO || scancode == PS2_OVR_HI) begin
                // Keyboard buffer overrun: nothing held can be trusted any more.
                matrix    <= '0;
                dec_state <= DEC_IDLE;
            end else begin
                if (key.valid) begin
                    matrix[key.row][key.col] <= ~dec_rel;
                end
                dec_state <= DEC_IDLE;
            end
        end
    end

    // Selected half-rows pull columns low together, like the real membrane.
    always_comb begin
        pressed = '0;
        for (int r = 0; r < 8; r++) begin
            if (!a[r]) begin
                pressed = pressed | matrix[r];
            end
        end
        kbcolumns = ~pressed;
    end

endmodule

// File: tb/tb_ps2_kbd_matrix.sv
// Bench for ps2_kbd_matrix: drives PS/2 frames, tracks expected bytes in a
// queue and expected key state in a behavioural matrix model.
module tb_ps2_kbd_matrix;

    localparam int HALF      = 25;
    localparam int HALF_REAL = 560;
    localparam int GAP       = 40;

    logic       clk14 = 1'b0;
    logic       reset_n = 1'b0;
    logic       ps2clk = 1'b1;
    logic       ps2data = 1'b1;
    logic [7:0] a = 8'hFF;
    logic [4:0] kbcolumns;
    logic [7:0] scancode;
    logic       scancode_valid;
    logic       rx_error;

    int n_checks = 0;
    int n_fail   = 0;
    int sv_cnt   = 0;
    int rx_err_cnt = 0;
    int rx_err_exp = 0;

    logic [7:0] exp_q[$];
    logic [7:0] exp_b;

    logic [4:0] mdl [8];
    bit         mrel, mext;

    logic [7:0] key_tab [8][5] = '{
        '{8'h12, 8'h1A, 8'h22, 8'h21, 8'h2A},
        '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34},
        '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C},
        '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E},
        '{8'h45, 8'h46, 8'h3E, 8'h3D, 8'h36},
        '{8'h4D, 8'h44, 8'h43, 8'h3C, 8'h35},
        '{8'h5A, 8'h4B, 8'h42, 8'h3B, 8'h33},
        '{8'h29, 8'h14, 8'h3A, 8'h31, 8'h32}
    };

    ps2_kbd_matrix dut (
        .clk14          (clk14),
        .reset_n        (reset_n),
        .ps2clk         (ps2clk),
        .ps2data        (ps2data),
        .a              (a),
        .kbcolumns      (kbcolumns),
        .scancode       (scancode),
        .scancode_valid (scancode_valid),
        .rx_error       (rx_error)
    );

    // Clock
    always #5 clk14 = ~clk14;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: key position as row*8+col, or -1 when not a key.
    function automatic int find_key(input logic [7:0] b, input bit ext);
        if (ext && !(b == 8'h14 || b == 8'h5A)) return -1;
        if (!ext && b == 8'h59) return 0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 5; c++)
                if (key_tab[r][c] == b) return r * 8 + c;
        return -1;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < 8; r++) mdl[r] = 5'b0;
        mrel = 0;
        mext = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        int k;
        if (b == 8'hF0) mrel = 1;
        else if (b == 8'hE0) mext = 1;
        else if (b == 8'hE1) begin end
        else if (b == 8'hAA && !mrel && !mext) begin end
        else if (b == 8'h00 || b == 8'hFF) model_clear();
        else begin
            k = find_key(b, mext);
            if (k >= 0) mdl[k / 8][k % 8] = !mrel;
            mrel = 0;
            mext = 0;
        end
    endtask

    function automatic logic [4:0] model_cols(input logic [7:0] sel);
        logic [4:0] acc = 5'b0;
        for (int r = 0; r < 8; r++)
            if (!sel[r]) acc = acc | mdl[r];
        return ~acc;
    endfunction

    // Driver tasks
    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk14);
        #1;
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n, input int half);
        for (int i = 0; i < n; i++) begin
            ps2data = bits[i];
            wait_cycles(half);
            ps2clk = 1'b0;
            wait_cycles(half);
            ps2clk = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_parity, input int half);
        logic p;
        p = ~(^b) ^ bad_parity;
        send_bits({1'b1, p, b, 1'b0}, 11, half);
        wait_cycles(GAP);
    endtask

    task automatic send_good(input logic [7:0] b, input int half);
        exp_q.push_back(b);
        model_byte(b);
        send_frame(b, 1'b0, half);
    endtask

    task automatic check_cols(input string tag, input logic [7:0] sel);
        a = sel;
        @(negedge clk14);
        check_value(tag, kbcolumns, model_cols(sel));
    endtask

    // Scoreboard: every scancode_valid must match the next queued byte.
    always @(negedge clk14) begin
        if (reset_n && scancode_valid) begin
            sv_cnt++;
            check_value("sv_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                exp_b = exp_q.pop_front();
                check_value("scancode", scancode, exp_b);
            end
        end
        if (reset_n && rx_error) rx_err_cnt++;
    end

    initial begin
        int sv0, pick;
        logic [7:0] b;
        model_clear();

        // Reset
        reset_n = 1'b0;
        a = 8'h00;
        wait_cycles(5);
        @(negedge clk14);
        check_value("rst_cols", kbcolumns, 5'b11111);
        check_value("rst_scancode", scancode, 8'h00);
        check_value("rst_sv", scancode_valid, 1'b0);
        check_value("rst_err", rx_error, 1'b0);
        wait_cycles(1);
        reset_n = 1'b1;
        wait_cycles(20);

        // Press A at a real 12.5 kHz keyboard clock
        send_good(8'h1C, HALF_REAL);
        check_cols("t1_row1", 8'hFD);
        check_cols("t1_row0", 8'hFE);

        // Release A
        sv0 = sv_cnt;
        send_good(8'hF0, HALF);
        send_good(8'h1C, HALF);
        check_cols("t2_row1", 8'hFD);
        check_value("t2_sv_count", sv_cnt - sv0, 2);
        check_value("t2_rx_err", rx_err_cnt, rx_err_exp);

        // Caps shift + 1, two rows combined
        send_good(8'h12, HALF);
        send_good(8'h16, HALF);
        check_cols("t3_rows03", 8'hF6);
        check_cols("t3_all", 8'h00);

        // Extended enter, ignored extended code, extended release
        send_good(8'hE0, HALF);
        send_good(8'h5A, HALF);
        check_cols("t4_enter", 8'hBF);
        send_good(8'hE0, HALF);
        send_good(8'h75, HALF);
        check_cols("t4_e075", 8'h00);
        send_good(8'hE0, HALF);
        send_good(8'hF0, HALF);
        send_good(8'h5A, HALF);
        check_cols("t4_enter_rel", 8'hBF);

        // Bad parity, then timeout abort, then recovery
        sv0 = sv_cnt;
        send_frame(8'h1C, 1'b1, HALF);
        rx_err_exp++;
        check_value("t5_parity_err", rx_err_cnt, rx_err_exp);
        check_value("t5_no_sv", sv_cnt - sv0, 0);
        check_cols("t5_row1", 8'hFD);
        send_bits(11'b000_0011_1000, 5, HALF);
        ps2data = 1'b1;
        wait_cycles(16400);
        rx_err_exp++;
        check_value("t5_timeout_err", rx_err_cnt, rx_err_exp);
        send_good(8'h1B, HALF);
        check_cols("t5_recover", 8'hFD);

        // Reset mid-frame while space is held
        send_good(8'h29, HALF);
        check_cols("t6_space", 8'h7F);
        send_bits(11'b000_0011_1000, 4, HALF);
        reset_n = 1'b0;
        wait_cycles(1);
        reset_n = 1'b1;
        ps2data = 1'b1;
        model_clear();
        wait_cycles(200);
        check_cols("t6_after_rst", 8'h7F);
        check_value("t6_scancode_rst", scancode, 8'h00);
        send_good(8'h29, HALF);
        check_cols("t6_space_again", 8'h7F);
        send_good(8'h2A, HALF);
        send_good(8'hFF, HALF);
        check_cols("t6_overrun", 8'h00);

        // Randomized byte stream
        for (int i = 0; i < 40; i++) begin
            pick = $urandom_range(0, 99);
            if (pick < 55) b = key_tab[$urandom_range(0, 7)][$urandom_range(0, 4)];
            else if (pick < 58) b = 8'h59;
            else if (pick < 75) b = 8'hF0;
            else if (pick < 85) b = 8'hE0;
            else if (pick < 92) b = 8'($urandom_range(0, 255));
            else if (pick < 96) b = (pick < 94) ? 8'hE1 : 8'hAA;
            else b = (pick < 98) ? 8'h00 : 8'hFF;
            send_good(b, HALF);
            check_cols("rnd_any", 8'($urandom_range(0, 255)));
            check_cols("rnd_row", ~(8'h01 << $urandom_range(0, 7)));
        end

        check_value("final_rx_err", rx_err_cnt, rx_err_exp);
        check_value("exp_q_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
